rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (`RegWrite` / `WriteReg` / `D`) between two writeback sources:
  - A: ALU/execute result.
  - B: load unit.
- Each source has a valid/ready handshake and a one-entry holding buffer, with round-robin arbitration between them.
- A 32-entry busy scoreboard tracks destination registers that have issued but not yet been written, and flags read hazards to the issue stage.
- Sits between the execute/memory stages and the register file.

---
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between the execute (A) and load (B) writeback paths.
// Each path has a one-entry holding buffer; a 32-entry busy scoreboard reports read hazards.
module rf_write_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [4:0]   a_rd,
    input  logic [N-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [4:0]   b_rd,
    input  logic [N-1:0] b_data,
    output logic         rf_we,
    output logic [4:0]   rf_wreg,
    output logic [N-1:0] rf_wdata,
    input  logic         issue_valid,
    input  logic [4:0]   issue_rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic         hazard,
    output logic [31:0]  busy
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic         r_a_full;
    logic [4:0]   r_a_rd;
    logic [N-1:0] r_a_data;
    logic         r_b_full;
    logic [4:0]   r_b_rd;
    logic [N-1:0] r_b_data;
    logic         r_last_grant;
    logic         r_rf_we;
    logic [4:0]   r_rf_wreg;
    logic [N-1:0] r_rf_wdata;
    logic [31:0]  r_busy;

    logic         w_grant_a;
    logic         w_grant_b;
    logic         w_a_load;
    logic         w_b_load;
    logic [31:0]  w_busy_d;

    // Grants depend only on buffer state, so ready never depends on valid.
    always_comb begin
        w_grant_a = r_a_full & (~r_b_full | (r_last_grant == SRC_B));
        w_grant_b = r_b_full & (~r_a_full | (r_last_grant == SRC_A));
    end

    assign a_ready = ~r_a_full | w_grant_a;
    assign b_ready = ~r_b_full | w_grant_b;

    // Writes to x0 complete the handshake but are dropped here.
    assign w_a_load = a_valid & a_ready & (a_rd != 5'd0);
    assign w_b_load = b_valid & b_ready & (b_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_full <= 1'b0;
            r_a_rd   <= 5'd0;
            r_a_data <= '0;
        end else if (w_a_load) begin
            r_a_full <= 1'b1;
            r_a_rd   <= a_rd;
            r_a_data <= a_data;
        end else if (w_grant_a) begin
            r_a_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b_full <= 1'b0;
            r_b_rd   <= 5'd0;
            r_b_data <= '0;
        end else if (w_b_load) begin
            r_b_full <= 1'b1;
            r_b_rd   <= b_rd;
            r_b_data <= b_data;
        end else if (w_grant_b) begin
            r_b_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= SRC_B;
        end else if (w_grant_a) begin
            r_last_grant <= SRC_A;
        end else if (w_grant_b) begin
            r_last_grant <= SRC_B;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we    <= 1'b0;
            r_rf_wreg  <= 5'd0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_grant_a | w_grant_b;
            if (w_grant_a) begin
                r_rf_wreg  <= r_a_rd;
                r_rf_wdata <= r_a_data;
            end else if (w_grant_b) begin
                r_rf_wreg  <= r_b_rd;
                r_rf_wdata <= r_b_data;
            end
        end
    end

    // Clear lands on the edge the register file commits; a same-edge issue wins.
    always_comb begin
        w_busy_d = r_busy;
        if (r_rf_we) begin
            w_busy_d[r_rf_wreg] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_busy_d[issue_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_wreg  = r_rf_wreg;
    assign rf_wdata = r_rf_wdata;
    assign busy     = r_busy;
    assign hazard   = r_busy[rs1] | r_busy[rs2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, contention, x0, latency, back-to-back, collision.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fails  = 0;

    rf_write_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .rf_we      (rf_we),
        .rf_wreg    (rf_wreg),
        .rf_wdata   (rf_wdata),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rf_we"}, 64'(rf_we), 64'd0);
        check_eq({tag, "_rf_wreg"}, 64'(rf_wreg), 64'd0);
        check_eq({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_hazard"}, 64'(hazard), 64'd0);
        check_eq({tag, "_a_ready"}, 64'(a_ready), 64'd1);
        check_eq({tag, "_b_ready"}, 64'(b_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ai;
        int          bi;
        logic        acc_a;
        logic        acc_b;
        int          wq_rd[$];
        logic [31:0] wq_data[$];
        int          exp_rd[12];

        exp_rd = '{1, 11, 2, 12, 3, 13, 4, 14, 5, 15, 6, 16};

        rst = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0;

        // Power-on reset
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Contention: A writes rd 1..6, B writes rd 11..16, both always valid
        ai = 0;
        bi = 0;
        for (int c = 0; c < 20; c++) begin
            a_valid = (ai < 6);
            a_rd    = 5'(ai + 1);
            a_data  = 32'h1000 + 32'(ai + 1);
            b_valid = (bi < 6);
            b_rd    = 5'(bi + 11);
            b_data  = 32'h2000 + 32'(bi + 11);
            #1;
            if (c <= 10) begin
                check_eq($sformatf("ctn_a_ready_c%0d", c), 64'(a_ready),
                         64'((c == 0) || (c % 2 == 1)));
                check_eq($sformatf("ctn_b_ready_c%0d", c), 64'(b_ready),
                         64'((c == 0) || (c % 2 == 0)));
            end
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            tick();
            if (acc_a) ai++;
            if (acc_b) bi++;
            if (rf_we) begin
                wq_rd.push_back(int'(rf_wreg));
                wq_data.push_back(rf_wdata);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check_eq("ctn_a_accepted", 64'(ai), 64'd6);
        check_eq("ctn_b_accepted", 64'(bi), 64'd6);
        check_eq("ctn_write_count", 64'(wq_rd.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < wq_rd.size()) begin
                check_eq($sformatf("ctn_wreg_%0d", i), 64'(wq_rd[i]), 64'(exp_rd[i]));
                check_eq($sformatf("ctn_wdata_%0d", i), 64'(wq_data[i]),
                         64'((exp_rd[i] < 11 ? 32'h1000 : 32'h2000) + 32'(exp_rd[i])));
            end
        end
        tick();
        tick();

        // Register 0: accepted, discarded, never marked busy
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check_eq("x0_b_ready", 64'(b_ready), 64'd1);
        tick();
        b_valid = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("x0_rf_we_%0d", i), 64'(rf_we), 64'd0);
            tick();
        end
        check_eq("x0_busy", 64'(busy), 64'd0);

        // Single source A with latency and hazard tracking
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd5;
        #1;
        check_eq("sa_busy_set", 64'(busy), 64'h20);
        check_eq("sa_hazard_set", 64'(hazard), 64'd1);
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        tick();
        a_valid = 1'b0;
        check_eq("sa_k_rf_we", 64'(rf_we), 64'd0);
        check_eq("sa_k_hazard", 64'(hazard), 64'd1);
        tick();
        check_eq("sa_k1_rf_we", 64'(rf_we), 64'd1);
        check_eq("sa_k1_rf_wreg", 64'(rf_wreg), 64'd5);
        check_eq("sa_k1_rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check_eq("sa_k1_hazard", 64'(hazard), 64'd1);
        tick();
        check_eq("sa_k2_rf_we", 64'(rf_we), 64'd0);
        check_eq("sa_k2_busy", 64'(busy), 64'd0);
        check_eq("sa_k2_hazard", 64'(hazard), 64'd0);
        rs1 = 5'd0;

        // Back-to-back A: four writes, each committed two edges after acceptance
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_rd    = 5'(i + 1);
            a_data  = 32'h100 + 32'(i);
            #1;
            check_eq($sformatf("b2b_a_ready_%0d", i), 64'(a_ready), 64'd1);
            tick();
            if (i == 0) begin
                check_eq("b2b_rf_we_first", 64'(rf_we), 64'd0);
            end else begin
                check_eq($sformatf("b2b_rf_we_%0d", i), 64'(rf_we), 64'd1);
                check_eq($sformatf("b2b_rf_wreg_%0d", i), 64'(rf_wreg), 64'(i));
                check_eq($sformatf("b2b_rf_wdata_%0d", i), 64'(rf_wdata),
                         64'(32'h100 + 32'(i - 1)));
            end
        end
        a_valid = 1'b0;
        tick();
        check_eq("b2b_rf_we_last", 64'(rf_we), 64'd1);
        check_eq("b2b_rf_wreg_last", 64'(rf_wreg), 64'd4);
        check_eq("b2b_rf_wdata_last", 64'(rf_wdata), 64'h103);
        tick();
        check_eq("b2b_rf_we_done", 64'(rf_we), 64'd0);

        // Set/clear collision on rd 7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7777;
        tick();
        a_valid = 1'b0;
        tick();
        check_eq("col_rf_we", 64'(rf_we), 64'd1);
        check_eq("col_rf_wreg", 64'(rf_wreg), 64'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        check_eq("col_busy_kept", 64'(busy), 64'h80);
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7778;
        tick();
        a_valid = 1'b0;
        tick();
        check_eq("col_busy_before_2nd", 64'(busy), 64'h80);
        tick();
        check_eq("col_busy_cleared", 64'(busy), 64'd0);

        // Reset mid-stream with both buffers full and busy = 6
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0;
        check_eq("mr_busy_pre", 64'(busy), 64'h6);
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3333;
        b_valid = 1'b1; b_rd = 5'd13; b_data = 32'hD0D0;
        tick();
        tick();
        check_eq("mr_rf_we_pre", 64'(rf_we), 64'd1);
        rs1 = 5'd1;
        rs2 = 5'd2;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mr");
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("mr_post_rf_we_0", 64'(rf_we), 64'd0);
        tick();
        check_eq("mr_post_rf_we_1", 64'(rf_we), 64'd0);
        check_eq("mr_post_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
